// File: rtl/spi_responder_pkg.sv
// -----------------------------------------------------------------------------
// spi_responder_pkg
//   Shared definitions for the SPI responder and its master counterpart:
//   mode codes, frame-length lookup and the responder state encoding.
// -----------------------------------------------------------------------------
package spi_responder_pkg;

   // Mode codes are shared with the SPI master, so the encoding is fixed.
   typedef enum logic [1:0] {
      MODE_W8   = 2'd0,
      MODE_W9   = 2'd1,
      MODE_RD16 = 2'd2,
      MODE_OFF  = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int unsigned BITCNT_W = 5;
   localparam int unsigned RX_W     = 9;
   localparam int unsigned TX_W     = 16;

   // Number of sclk rises that make up one frame in the given mode.
   function automatic logic [BITCNT_W-1:0] frame_len(input mode_e m);
      logic [BITCNT_W-1:0] len;
      case (m)
         MODE_W8:   len = 5'd8;
         MODE_W9:   len = 5'd9;
         MODE_RD16: len = 5'd16;
         default:   len = 5'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/spi_responder_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_responder_edge_sync
//   Multi-flop synchronizer for an asynchronous level, followed by one extra
//   flop so that single-cycle rise/fall pulses can be derived in the clk domain.
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   d_i     in   asynchronous input level
//   rise_o  out  1-cycle pulse on a synchronized 0->1 transition
//   fall_o  out  1-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_responder_edge_sync #(
   parameter int unsigned SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STG-1:0] sync_q;
   logic                prev_q;
   logic                level_s;

   assign level_s = sync_q[SYNC_STG-1];

   // NOTE: non-blocking assignments let every flop sample the pre-edge value,
   // which is what makes this a shift chain rather than a single wire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], d_i};
         prev_q <= level_s;
      end
   end

   assign rise_o = level_s & ~prev_q;
   assign fall_o = ~level_s & prev_q;

endmodule

// File: rtl/spi_responder.sv
// -----------------------------------------------------------------------------
// spi_responder
//   Target side of the board SPI link (no chip-select). Frames are delimited by
//   bit count (8/9 write bits, 16 read bits) and by an idle timeout.
// Ports
//   clk        in   system clock, >=6x sclk rate
//   rst_n      in   asynchronous active-low reset
//   mode       in   0=write 8b, 1=write 9b, 2=read 16b, 3=disabled
//   sclk       in   serial clock from master (async)
//   din        in   serial data from master, MSB first
//   dout       out  serial data to master, MSB first
//   tx_word    in   read data, captured while idle
//   tx_valid   in   tx_word valid
//   tx_ack     out  1-cycle pulse: tx_word captured
//   rx_word    out  received word, right-justified
//   rx_valid   out  1-cycle pulse: rx_word updated
//   tx_done    out  1-cycle pulse: 16 read bits shifted out
//   frame_err  out  1-cycle pulse: timeout abort or read underrun
//   busy       out  high while a frame is in progress
// -----------------------------------------------------------------------------
module spi_responder
   import spi_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      mode,
   input  logic            sclk,
   input  logic            din,
   output logic            dout,
   input  logic [TX_W-1:0] tx_word,
   input  logic            tx_valid,
   output logic            tx_ack,
   output logic [RX_W-1:0] rx_word,
   output logic            rx_valid,
   output logic            tx_done,
   output logic            frame_err,
   output logic            busy
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   // ---------------------------------------------------------------- inputs
   logic                sclk_rise;
   logic                sclk_fall;
   logic [SYNC_STG-1:0] din_sync_q;
   logic                din_s;
   mode_e               mode_in;

   spi_responder_edge_sync #(
      .SYNC_STG (SYNC_STG)
   ) u_sclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (sclk),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   // din goes through the same depth as sclk so the sampled bit lines up with
   // the detected rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_sync_q <= '0;
      end else begin
         din_sync_q <= {din_sync_q[SYNC_STG-2:0], din};
      end
   end

   assign din_s   = din_sync_q[SYNC_STG-1];
   assign mode_in = mode_e'(mode);

   // ----------------------------------------------------------------- state
   state_e                state_q,     state_d;
   mode_e                 mode_q,      mode_d;
   logic [BITCNT_W-1:0]   bitcnt_q,    bitcnt_d;
   logic [RX_W-1:0]       rx_sh_q,     rx_sh_d;
   logic [TX_W-1:0]       tx_sh_q,     tx_sh_d;
   logic [TO_W-1:0]       idle_cnt_q,  idle_cnt_d;
   logic                  loaded_q,    loaded_d;
   logic                  underrun_q,  underrun_d;
   logic [RX_W-1:0]       rx_word_q,   rx_word_d;
   logic                  rx_valid_q,  rx_valid_d;
   logic                  tx_ack_q,    tx_ack_d;
   logic                  tx_done_q,   tx_done_d;
   logic                  frame_err_q, frame_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_W8;
         bitcnt_q    <= '0;
         rx_sh_q     <= '0;
         tx_sh_q     <= '0;
         idle_cnt_q  <= '0;
         loaded_q    <= 1'b0;
         underrun_q  <= 1'b0;
         rx_word_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_ack_q    <= 1'b0;
         tx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         bitcnt_q    <= bitcnt_d;
         rx_sh_q     <= rx_sh_d;
         tx_sh_q     <= tx_sh_d;
         idle_cnt_q  <= idle_cnt_d;
         loaded_q    <= loaded_d;
         underrun_q  <= underrun_d;
         rx_word_q   <= rx_word_d;
         rx_valid_q  <= rx_valid_d;
         tx_ack_q    <= tx_ack_d;
         tx_done_q   <= tx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   // -------------------------------------------------------- next state
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      mode_d      = mode_q;
      bitcnt_d    = bitcnt_q;
      rx_sh_d     = rx_sh_q;
      tx_sh_d     = tx_sh_q;
      idle_cnt_d  = idle_cnt_q;
      loaded_d    = loaded_q;
      underrun_d  = underrun_q;
      rx_word_d   = rx_word_q;
      rx_valid_d  = 1'b0;
      tx_ack_d    = 1'b0;
      tx_done_d   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            bitcnt_d   = '0;
            idle_cnt_d = '0;
            if ((mode_in != MODE_OFF) && sclk_rise) begin
               // The first rise is bit 1 of the new frame. A read frame that
               // starts without a captured word is flagged as an underrun; the
               // shift register is already zero in that case.
               state_d    = ST_SHIFT;
               mode_d     = mode_in;
               rx_sh_d    = {rx_sh_q[RX_W-2:0], din_s};
               bitcnt_d   = 5'd1;
               underrun_d = (mode_in == MODE_RD16) && !loaded_q;
            end else if ((mode_in == MODE_RD16) && !loaded_q && tx_valid) begin
               // One capture per read frame; the word is held until the frame
               // that consumes it completes or aborts.
               tx_sh_d  = tx_word;
               tx_ack_d = 1'b1;
               loaded_d = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (sclk_rise || sclk_fall) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end

            if (sclk_rise) begin
               rx_sh_d  = {rx_sh_q[RX_W-2:0], din_s};
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_d == frame_len(mode_q)) begin
                  state_d = ST_DONE;
               end
            end

            // The master samples on rise, so the next bit is presented on fall.
            if (sclk_fall && (mode_q == MODE_RD16)) begin
               tx_sh_d = {tx_sh_q[TX_W-2:0], 1'b0};
            end

            if (!sclk_rise && !sclk_fall && (idle_cnt_q == TO_W'(TIMEOUT - 1))) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               underrun_d  = 1'b0;
               if (mode_q == MODE_RD16) begin
                  loaded_d = 1'b0;
                  tx_sh_d  = '0;
               end
            end
         end

         ST_DONE: begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            if (mode_q == MODE_RD16) begin
               tx_done_d   = 1'b1;
               frame_err_d = underrun_q;
               underrun_d  = 1'b0;
               loaded_d    = 1'b0;
               tx_sh_d     = '0;
            end else begin
               rx_valid_d = 1'b1;
               if (mode_q == MODE_W9) begin
                  rx_word_d = rx_sh_q;
               end else begin
                  rx_word_d = {1'b0, rx_sh_q[7:0]};
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- outputs
   // A disabled responder keeps dout low while idle, whatever is pending.
   assign dout      = tx_sh_q[TX_W-1] & ~((state_q == ST_IDLE) && (mode_in == MODE_OFF));
   assign tx_ack    = tx_ack_q;
   assign rx_word   = rx_word_q;
   assign rx_valid  = rx_valid_q;
   assign tx_done   = tx_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_responder
//   Drives the responder as an SPI master would, predicts every output pulse
//   from the frame rules, and compares in an independent monitor.
// -----------------------------------------------------------------------------
module tb_spi_responder;

   localparam int TIMEOUT  = 64;
   localparam int SYNC_STG = 2;
   localparam int HALF     = 4;   // clk cycles per sclk phase

   typedef struct {
      bit          rxv;
      bit          txd;
      bit          ferr;
      logic [8:0]  rxw;
      logic [15:0] rdw;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mode;
   logic        sclk;
   logic        din;
   logic        dout;
   logic [15:0] tx_word;
   logic        tx_valid;
   logic        tx_ack;
   logic [8:0]  rx_word;
   logic        rx_valid;
   logic        tx_done;
   logic        frame_err;
   logic        busy;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          cyc    = 0;
   int          ack_cnt = 0;
   int          last_rise_cyc = 0;
   int          last_edge_cyc = 0;
   logic [15:0] rd_cap = '0;
   logic [8:0]  last_good = '0;
   exp_t        sb_q[$];

   spi_responder #(
      .TIMEOUT  (TIMEOUT),
      .SYNC_STG (SYNC_STG)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sclk      (sclk),
      .din       (din),
      .dout      (dout),
      .tx_word   (tx_word),
      .tx_valid  (tx_valid),
      .tx_ack    (tx_ack),
      .rx_word   (rx_word),
      .rx_valid  (rx_valid),
      .tx_done   (tx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (rst_n && tx_ack) ack_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // ------------------------------------------------------------ ref model
   function automatic exp_t model_write(input int len, input logic [15:0] w);
      exp_t e;
      int   val;
      val    = int'(w) % (1 << len);
      e.rxv  = 1'b1;
      e.txd  = 1'b0;
      e.ferr = 1'b0;
      e.rxw  = 9'(val);
      e.rdw  = '0;
      return e;
   endfunction

   function automatic exp_t model_read(input bit v, input logic [15:0] w);
      exp_t e;
      e.rxv  = 1'b0;
      e.txd  = 1'b1;
      e.ferr = !v;
      e.rxw  = '0;
      e.rdw  = v ? w : 16'h0000;
      return e;
   endfunction

   function automatic exp_t model_timeout();
      exp_t e;
      e.rxv  = 1'b0;
      e.txd  = 1'b0;
      e.ferr = 1'b1;
      e.rxw  = '0;
      e.rdw  = '0;
      return e;
   endfunction

   // -------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      exp_t e;
      int   lat;
      if (rst_n && (rx_valid || tx_done || frame_err)) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pulse: got rx_valid=%0b tx_done=%0b frame_err=%0b, expected no pulse (t=%0t)",
                     rx_valid, tx_done, frame_err, $time);
         end else begin
            e = sb_q.pop_front();
            check("pulse_set", 32'({rx_valid, tx_done, frame_err}), 32'({e.rxv, e.txd, e.ferr}));
            if (e.rxv) begin
               check("rx_word", 32'(rx_word), 32'(e.rxw));
               check("rx_latency", 32'(cyc - last_rise_cyc), 32'(SYNC_STG + 2));
            end
            if (e.txd) begin
               check("read_word", 32'(rd_cap), 32'(e.rdw));
            end
            if (e.ferr && !e.txd) begin
               lat = cyc - last_edge_cyc;
               n_chk++;
               if (lat >= TIMEOUT && lat <= TIMEOUT + SYNC_STG + 2) n_pass++;
               else $display("FAIL timeout_latency: got %0d cycles, expected %0d..%0d",
                             lat, TIMEOUT, TIMEOUT + SYNC_STG + 2);
            end
         end
      end
   end

   // --------------------------------------------------------------- master
   // Drives din while sclk is low, samples dout just before raising sclk.
   // rst_at >= 0 pulses reset while sclk is high on that bit and abandons the frame.
   task automatic spi_frame(input int nbits, input logic [15:0] wdata, input int rst_at);
      rd_cap = '0;
      for (int i = 0; i < nbits; i++) begin
         din = wdata[nbits-1-i];
         repeat (HALF) @(negedge clk);
         rd_cap = {rd_cap[14:0], dout};
         sclk = 1'b1;
         last_rise_cyc = cyc;
         last_edge_cyc = cyc;
         repeat (HALF) @(negedge clk);
         if (i == rst_at) begin
            rst_n = 1'b0;
            sclk  = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            din   = 1'b0;
            return;
         end
         sclk = 1'b0;
         last_edge_cyc = cyc;
      end
      din = 1'b0;
   endtask

   task automatic write_frame(input logic [1:0] m, input logic [15:0] w);
      exp_t e;
      int   len;
      mode = m;
      @(negedge clk);
      len = (m == 2'd1) ? 9 : 8;
      e = model_write(len, w);
      sb_q.push_back(e);
      last_good = e.rxw;
      spi_frame(len, w, -1);
      repeat (10) @(negedge clk);
   endtask

   task automatic read_frame(input bit v, input logic [15:0] w);
      int a0;
      bit got;
      mode = 2'd2;
      @(negedge clk);
      a0 = ack_cnt;
      if (v) begin
         tx_word  = w;
         tx_valid = 1'b1;
         got      = 1'b0;
         for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (tx_ack) got = 1'b1;
         end
         tx_valid = 1'b0;
         check("ack_seen", 32'(got), 32'(1));
      end
      // Changes to tx_word after capture must not reach dout.
      tx_word = 16'($urandom);
      sb_q.push_back(model_read(v, w));
      spi_frame(16, 16'($urandom), -1);
      repeat (12) @(negedge clk);
      check("ack_count", 32'(ack_cnt - a0), 32'(v));
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
   endtask

   // ---------------------------------------------------------------- main
   initial begin : main
      rst_n    = 1'b0;
      sclk     = 1'b0;
      din      = 1'b0;
      mode     = 2'd0;
      tx_word  = '0;
      tx_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rx_word",   32'(rx_word),   32'(0));
      check("rst_rx_valid",  32'(rx_valid),  32'(0));
      check("rst_tx_ack",    32'(tx_ack),    32'(0));
      check("rst_tx_done",   32'(tx_done),   32'(0));
      check("rst_frame_err", 32'(frame_err), 32'(0));
      check("rst_busy",      32'(busy),      32'(0));
      check("rst_dout",      32'(dout),      32'(0));
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      write_frame(2'd0, 16'h00A5);
      write_frame(2'd1, 16'h01C3);
      read_frame(1'b1, 16'hBEEF);
      read_frame(1'b0, 16'h1234);

      // Partial frame aborted by the idle timeout; rx_word must hold.
      mode = 2'd0;
      @(negedge clk);
      sb_q.push_back(model_timeout());
      spi_frame(5, 16'h0015, -1);
      repeat (TIMEOUT + 20) @(negedge clk);
      check("rx_hold_after_timeout", 32'(rx_word), 32'(last_good));
      check("busy_after_timeout",    32'(busy),    32'(0));
      write_frame(2'd0, 16'h003C);
      drain();

      // Reset in the middle of bit 4 discards the frame.
      mode = 2'd0;
      @(negedge clk);
      spi_frame(8, 16'h00FF, 3);
      check("busy_after_reset",    32'(busy),    32'(0));
      check("rx_word_after_reset", 32'(rx_word), 32'(0));
      last_good = '0;
      repeat (4) @(negedge clk);
      write_frame(2'd0, 16'h0081);

      // Disabled: sclk activity must produce nothing.
      mode = 2'd3;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         din = 1'($urandom);
         repeat (HALF) @(negedge clk);
         check("off_dout", 32'(dout), 32'(0));
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         check("off_busy", 32'(busy), 32'(0));
         sclk = 1'b0;
      end
      repeat (4) @(negedge clk);

      // Randomized mix of frames.
      for (int i = 0; i < 12; i++) begin
         int          m;
         logic [15:0] w;
         m = int'($urandom_range(0, 2));
         w = 16'($urandom);
         if (m == 2) read_frame(1'($urandom_range(0, 1)), w);
         else        write_frame(2'(m), w);
      end
      check("rx_word_final", 32'(rx_word), 32'(last_good));

      drain();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
